wb_trace_fifo: RTL and testbench

Observer-side companion to the single-cycle CPU. It captures every architectural write-back the CPU commits, both GRF writes and data-memory stores, and buffers them in a FIFO. The buffered events are presented on a ready/valid port that a host harness or checker drains at its own pace. It sits beside `Main`, taps the GRF and DM write strobes, and never back-pressures the CPU; events that cannot be buffered are dropped and flagged.

---
 rtl/wb_trace_fifo.sv | 111 +++++++++++
 tb/tb_wb_trace_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_fifo.sv
// Write-back trace FIFO: captures GRF and DM commits from the CPU and presents them on a ready/valid port.
// Optional macro WB_TRACE_DROP_CNT_EN adds a saturating 16-bit DropCnt output.
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [31:0]   Pc,
    input  logic          GRFWe,
    input  logic [4:0]    GRFAddr,
    input  logic [31:0]   GRFData,
    input  logic          DMWe,
    input  logic [31:0]   DMAddr,
    input  logic [31:0]   DMData,
    output logic          TrValid,
    input  logic          TrReady,
    output logic          TrKind,
    output logic [31:0]   TrPc,
    output logic [31:0]   TrAddr,
    output logic [31:0]   TrData,
    output logic [AW:0]   Count,
    output logic          Overflow
`ifdef WB_TRACE_DROP_CNT_EN
    ,
    output logic [15:0]   DropCnt
`endif
);

    localparam int FW = AW + 2;

    logic [DEPTH-1:0] kind_mem;
    logic [31:0]      pc_mem   [DEPTH];
    logic [31:0]      addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic [AW-1:0] wptr, rptr, dm_slot;
    logic [AW:0]   cnt;
    logic          ovf;
    logic          grf_ev, dm_ev, pop, grf_push, dm_push;
    logic [FW-1:0] free;
    logic [1:0]    pushes, drops;

    // Events in a reset cycle are ignored entirely, so they never reach the push or drop logic.
    always_comb begin
        grf_ev   = !Reset && GRFWe && (GRFAddr != 5'd0);
        dm_ev    = !Reset && DMWe;
        pop      = (cnt != '0) && TrReady;
        free     = FW'(DEPTH) - FW'(cnt) + FW'(pop);
        grf_push = grf_ev && (free >= FW'(1));
        dm_push  = dm_ev && (grf_ev ? (free >= FW'(2)) : (free >= FW'(1)));
        dm_slot  = wptr + AW'(grf_push);
        pushes   = 2'(grf_push) + 2'(dm_push);
        drops    = 2'(grf_ev && !grf_push) + 2'(dm_ev && !dm_push);
    end

    always_ff @(posedge Clk) begin
        if (grf_push) begin
            kind_mem[wptr] <= 1'b0;
            pc_mem[wptr]   <= Pc;
            addr_mem[wptr] <= {27'd0, GRFAddr};
            data_mem[wptr] <= GRFData;
        end
        if (dm_push) begin
            kind_mem[dm_slot] <= 1'b1;
            pc_mem[dm_slot]   <= Pc;
            addr_mem[dm_slot] <= DMAddr;
            data_mem[dm_slot] <= DMData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            wptr <= wptr + AW'(pushes);
            rptr <= rptr + AW'(pop);
            cnt  <= cnt + (AW+1)'(pushes) - (AW+1)'(pop);
            if (drops != 2'd0)
                ovf <= 1'b1;
        end
    end

`ifdef WB_TRACE_DROP_CNT_EN
    logic [16:0] drop_sum;
    logic [15:0] drop_cnt;

    assign drop_sum = {1'b0, drop_cnt} + 17'(drops);

    always_ff @(posedge Clk) begin
        if (Reset)
            drop_cnt <= '0;
        else
            drop_cnt <= drop_sum[16] ? '1 : drop_sum[15:0];
    end

    assign DropCnt = drop_cnt;
`endif

    assign TrValid  = (cnt != '0);
    assign TrKind   = kind_mem[rptr];
    assign TrPc     = pc_mem[rptr];
    assign TrAddr   = addr_mem[rptr];
    assign TrData   = data_mem[rptr];
    assign Count    = cnt;
    assign Overflow = ovf;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Directed self-checking bench for wb_trace_fifo (DEPTH=16); DropCnt checks enabled with WB_TRACE_DROP_CNT_EN.
module tb_wb_trace_fifo;

    logic        Clk = 1'b0;
    logic        Reset, GRFWe, DMWe, TrReady;
    logic [31:0] Pc, GRFData, DMAddr, DMData;
    logic [4:0]  GRFAddr;
    logic        TrValid, TrKind, Overflow;
    logic [31:0] TrPc, TrAddr, TrData;
    logic [4:0]  Count;
`ifdef WB_TRACE_DROP_CNT_EN
    logic [15:0] DropCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    wb_trace_fifo #(.DEPTH(16), .AW(4)) dut (
        .Clk(Clk), .Reset(Reset), .Pc(Pc),
        .GRFWe(GRFWe), .GRFAddr(GRFAddr), .GRFData(GRFData),
        .DMWe(DMWe), .DMAddr(DMAddr), .DMData(DMData),
        .TrValid(TrValid), .TrReady(TrReady), .TrKind(TrKind),
        .TrPc(TrPc), .TrAddr(TrAddr), .TrData(TrData),
        .Count(Count), .Overflow(Overflow)
`ifdef WB_TRACE_DROP_CNT_EN
        , .DropCnt(DropCnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; outputs are sampled and inputs changed 1 time unit later.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        GRFWe = 1'b0; DMWe = 1'b0; GRFAddr = '0; GRFData = '0;
        DMAddr = '0; DMData = '0; Pc = '0;
    endtask

    task automatic grf(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d);
        Pc = pc; GRFWe = 1'b1; GRFAddr = a; GRFData = d;
    endtask

    task automatic dm(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] d);
        Pc = pc; DMWe = 1'b1; DMAddr = a; DMData = d;
    endtask

    logic [31:0] exp_d;

    initial begin
        idle();
        Reset = 1'b1; TrReady = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        check("rst_count", 32'(Count), 32'd0);
        check("rst_valid", 32'(TrValid), 32'd0);
        check("rst_ovf", 32'(Overflow), 32'd0);
`ifdef WB_TRACE_DROP_CNT_EN
        check("rst_dropcnt", 32'(DropCnt), 32'd0);
`endif

        // Single GRF write, consumer always ready
        TrReady = 1'b1;
        grf(32'h3000, 5'd8, 32'h1234);
        tick();
        idle();
        check("g1_valid", 32'(TrValid), 32'd1);
        check("g1_kind", 32'(TrKind), 32'd0);
        check("g1_addr", TrAddr, 32'd8);
        check("g1_data", TrData, 32'h1234);
        check("g1_pc", TrPc, 32'h3000);
        tick();
        check("g1_count_after_pop", 32'(Count), 32'd0);

        // Writes to $0 are ignored
        for (int i = 0; i < 5; i++) begin
            grf(32'h3100, 5'd0, 32'hDEAD);
            tick();
            check("r0_count", 32'(Count), 32'd0);
            check("r0_ovf", 32'(Overflow), 32'd0);
        end
        idle();
`ifdef WB_TRACE_DROP_CNT_EN
        check("r0_dropcnt", 32'(DropCnt), 32'd0);
`endif

        // Dual event in one cycle
        TrReady = 1'b0;
        grf(32'h3004, 5'd3, 32'd5);
        dm(32'h3004, 32'h10, 32'hAB);
        tick();
        idle();
        check("dual_count", 32'(Count), 32'd2);
        check("dual0_kind", 32'(TrKind), 32'd0);
        check("dual0_addr", TrAddr, 32'd3);
        check("dual0_data", TrData, 32'd5);
        check("dual0_pc", TrPc, 32'h3004);
        tick();
        check("dual_hold_data", TrData, 32'd5);
        TrReady = 1'b1;
        tick();
        check("dual1_count", 32'(Count), 32'd1);
        check("dual1_kind", 32'(TrKind), 32'd1);
        check("dual1_addr", TrAddr, 32'h10);
        check("dual1_data", TrData, 32'hAB);
        check("dual1_pc", TrPc, 32'h3004);
        tick();
        check("dual_drained", 32'(Count), 32'd0);
        tick();
        check("ready_while_empty", 32'(Count), 32'd0);

        // Fill past capacity: 17 pushes, 1 drop
        TrReady = 1'b0;
        for (int i = 0; i < 17; i++) begin
            grf(32'h4000 + 32'(4 * i), 5'((i % 31) + 1), 32'h100 + 32'(i));
            tick();
        end
        idle();
        check("full_count", 32'(Count), 32'd16);
        check("full_ovf", 32'(Overflow), 32'd1);
        check("full_head", TrData, 32'h100);
`ifdef WB_TRACE_DROP_CNT_EN
        check("full_dropcnt", 32'(DropCnt), 32'd1);
`endif

        // Full: pop + single push is stored
        TrReady = 1'b1;
        grf(32'h5000, 5'd20, 32'h500);
        tick();
        idle();
        check("fpop1_count", 32'(Count), 32'd16);
        check("fpop1_head", TrData, 32'h101);
`ifdef WB_TRACE_DROP_CNT_EN
        check("fpop1_dropcnt", 32'(DropCnt), 32'd1);
`endif

        // Full: pop + dual, GRF kept and DM dropped
        grf(32'h5004, 5'd21, 32'h600);
        dm(32'h5004, 32'h20, 32'h700);
        tick();
        idle();
        check("fpop2_count", 32'(Count), 32'd16);
        check("fpop2_head", TrData, 32'h102);
`ifdef WB_TRACE_DROP_CNT_EN
        check("fpop2_dropcnt", 32'(DropCnt), 32'd2);
`endif

        // Drain everything in order
        for (int k = 0; k < 16; k++) begin
            exp_d = (k < 14) ? 32'h102 + 32'(k) : (k == 14) ? 32'h500 : 32'h600;
            check("drain_valid", 32'(TrValid), 32'd1);
            check("drain_data", TrData, exp_d);
            if (k < 14)
                check("drain_pc", TrPc, 32'h4000 + 32'(4 * (k + 2)));
            if (k == 15) begin
                check("drain_last_addr", TrAddr, 32'd21);
                check("drain_last_kind", 32'(TrKind), 32'd0);
            end
            tick();
        end
        check("drain_count", 32'(Count), 32'd0);
        check("drain_valid_low", 32'(TrValid), 32'd0);

        // Reset mid-operation with a DM event present
        TrReady = 1'b0;
        for (int i = 0; i < 10; i++) begin
            grf(32'h6000 + 32'(4 * i), 5'd9, 32'h900 + 32'(i));
            tick();
        end
        idle();
        check("ten_count", 32'(Count), 32'd10);
        Reset = 1'b1;
        dm(32'h7000, 32'h30, 32'h77);
        tick();
        Reset = 1'b0;
        idle();
        check("mrst_count", 32'(Count), 32'd0);
        check("mrst_valid", 32'(TrValid), 32'd0);
        check("mrst_ovf", 32'(Overflow), 32'd0);
`ifdef WB_TRACE_DROP_CNT_EN
        check("mrst_dropcnt", 32'(DropCnt), 32'd0);
`endif
        tick();
        check("mrst_dm_not_stored", 32'(Count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
